// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: FSM states,
// RV32I load/store funct3 codes and access-legality helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_RESP = 2'd1,
        RMW_MERGE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Word accesses need off==0, halfword accesses need an even offset.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b10:   return off != 2'b00;
            2'b01:   return off[0];
            default: return 1'b0;
        endcase
    endfunction

    // Stores only have SB/SH/SW; loads additionally have LBU/LHU.
    function automatic logic is_legal(input logic [2:0] funct3, input logic is_store);
        if (is_store) begin
            return funct3 == F3_SB || funct3 == F3_SH || funct3 == F3_SW;
        end
        return funct3 == F3_LB || funct3 == F3_LH || funct3 == F3_LW ||
               funct3 == F3_LBU || funct3 == F3_LHU;
    endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte/halfword lane handling: load extract + extend, and the merge step of
// a sub-word read-modify-write. Both share the same offset decode.
module lsu_lane_fmt
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rdata,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane, then extend it or splice the store data in.
    always_comb begin
        case (i_off)
            2'd0:    byte_sel = i_rdata[7:0];
            2'd1:    byte_sel = i_rdata[15:8];
            2'd2:    byte_sel = i_rdata[23:16];
            default: byte_sel = i_rdata[31:24];
        endcase
        half_sel = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_LB:   o_load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   o_load_data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   o_load_data = i_rdata;
            F3_LBU:  o_load_data = {24'd0, byte_sel};
            F3_LHU:  o_load_data = {16'd0, half_sel};
            default: o_load_data = 32'd0;
        endcase

        o_merged = i_rdata;
        if (i_funct3 == F3_SB) begin
            case (i_off)
                2'd0:    o_merged[7:0]   = i_wdata[7:0];
                2'd1:    o_merged[15:8]  = i_wdata[7:0];
                2'd2:    o_merged[23:16] = i_wdata[7:0];
                default: o_merged[31:24] = i_wdata[7:0];
            endcase
        end else if (i_funct3 == F3_SH) begin
            if (i_off[1]) begin
                o_merged[31:16] = i_wdata;
            end else begin
                o_merged[15:0] = i_wdata;
            end
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store initiator for a word-wide data memory without byte
// enables. Loads and SB/SH take two cycles (one stall); SW takes one.
// Memory handshake: the address is presented in cycle N and i_dmem_rdata is
// valid in cycle N+1; o_dmem_we writes in the cycle it is high.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [2:0]            i_funct3,
    input  logic [31:0]           i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_dmem_we,
    output logic [ADDR_WIDTH-1:0] o_dmem_addr,
    output logic [DATA_WIDTH-1:0] o_dmem_wdata,
    input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
    output logic                  o_stall,
    output logic                  o_load_valid,
    output logic [DATA_WIDTH-1:0] o_load_data,
    output logic                  o_misaligned
);

    lsu_state_e            state_q, state_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [15:0]           wdata_q, wdata_d;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [1:0]            req_off;
    logic                  is_store;
    logic [31:0]           fmt_load;
    logic [31:0]           fmt_merged;

    // Address bits above the memory's word range wrap and are not used.
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_addr[31:ADDR_WIDTH+2];

    assign req_addr = i_addr[ADDR_WIDTH+1:2];
    assign req_off  = i_addr[1:0];

    lsu_lane_fmt u_lane_fmt (
        .i_funct3    (f3_q),
        .i_off       (off_q),
        .i_rdata     (i_dmem_rdata),
        .i_wdata     (wdata_q),
        .o_load_data (fmt_load),
        .o_merged    (fmt_merged)
    );

    // Request decode, FSM next state and output muxing; reset forces all outputs low.
    always_comb begin
        state_d      = state_q;
        f3_d         = f3_q;
        off_d        = off_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        is_store     = i_mem_write;
        o_dmem_we    = 1'b0;
        o_dmem_addr  = '0;
        o_dmem_wdata = '0;
        o_stall      = 1'b0;
        o_load_valid = 1'b0;
        o_load_data  = '0;
        o_misaligned = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_valid && (i_mem_read || i_mem_write)) begin
                    if (!is_legal(i_funct3, is_store)) begin
                        // illegal funct3: no-op
                    end else if (is_misaligned(i_funct3, req_off)) begin
                        o_misaligned = 1'b1;
                    end else if (is_store && i_funct3 == F3_SW) begin
                        o_dmem_we    = 1'b1;
                        o_dmem_addr  = req_addr;
                        o_dmem_wdata = i_wdata;
                    end else begin
                        o_stall     = 1'b1;
                        o_dmem_addr = req_addr;
                        f3_d        = i_funct3;
                        off_d       = req_off;
                        waddr_d     = req_addr;
                        wdata_d     = i_wdata[15:0];
                        state_d     = is_store ? RMW_MERGE : LOAD_RESP;
                    end
                end
            end
            LOAD_RESP: begin
                o_load_valid = 1'b1;
                o_load_data  = fmt_load;
                state_d      = IDLE;
            end
            RMW_MERGE: begin
                o_dmem_we    = 1'b1;
                o_dmem_addr  = waddr_q;
                o_dmem_wdata = fmt_merged;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (i_rst) begin
            o_dmem_we    = 1'b0;
            o_dmem_addr  = '0;
            o_dmem_wdata = '0;
            o_stall      = 1'b0;
            o_load_valid = 1'b0;
            o_load_data  = '0;
            o_misaligned = 1'b0;
        end
    end

    // State and captured request fields.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            f3_q    <= '0;
            off_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule
